rri_control_regbank: RTL

//  Parametrised AXI4-Lite slave register bank; next generation of the 4-register rri_control slave.

---
 rtl/rri_ctrl_pkg.sv | 32 +++
 rtl/rri_control_regbank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rri_ctrl_pkg.sv
// Shared types and helpers for the rri_control register bank.
package rri_ctrl_pkg;

    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_CAPT,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    function automatic logic [MAX_DATA_W-1:0] strb_to_mask(input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_DATA_W-1:0] mask;
        mask = '0;
        for (int unsigned b = 0; b < MAX_STRB_W; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rri_control_regbank.sv
// AXI4-Lite slave register bank: read/write control regs, read-only status regs,
// write-1-to-pulse regs, SLVERR on unmapped addresses.
module rri_control_regbank
    import rri_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter logic [63:0] RO_MASK    = '0,
    parameter logic [63:0] PULSE_MASK = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                 S_AXI_AWPROT,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [DATA_W-1:0]          S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic [1:0]                 S_AXI_BRESP,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                 S_AXI_ARPROT,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [DATA_W-1:0]          S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    output logic [N_REGS*DATA_W-1:0]   ctrl_o,
    output logic [N_REGS*DATA_W-1:0]   pulse_o,
    input  logic [N_REGS*DATA_W-1:0]   status_i
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = ADDR_W - ADDR_LSB;
    localparam logic [IDX_W:0] N_REGS_IDX = (IDX_W+1)'(N_REGS);

    wr_state_e                        wr_state_q, wr_state_d;
    rd_state_e                        rd_state_q, rd_state_d;
    logic                             live_q;
    logic                             aw_held_q, w_held_q;
    logic [IDX_W-1:0]                 aw_idx_q;
    logic [DATA_W-1:0]                wdata_q;
    logic [STRB_W-1:0]                wstrb_q;
    axi_resp_e                        bresp_q, bresp_d;
    logic [N_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
    logic [N_REGS-1:0][DATA_W-1:0]    pulse_q, pulse_d;
    logic [DATA_W-1:0]                rdata_q, rdata_d;
    axi_resp_e                        rresp_q, rresp_d;

    logic                             aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]                 ar_idx;
    logic [DATA_W-1:0]                wmask;
    logic                             unused_ok;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_idx = S_AXI_ARADDR[ADDR_W-1:ADDR_LSB];

    assign ctrl_o      = regs_q;
    assign pulse_o     = pulse_q;
    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0], status_i};

    // ---------------- write FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            W_IDLE:  if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) wr_state_d = W_CAPT;
            W_CAPT:  wr_state_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    // live_q keeps every READY low while reset is asserted and for the first cycle after.
    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                S_AXI_AWREADY = live_q && !aw_held_q;
                S_AXI_WREADY  = live_q && !w_held_q;
            end
            W_RESP:  S_AXI_BVALID = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wmask   = DATA_W'(strb_to_mask(MAX_STRB_W'(wstrb_q)));
        bresp_d = ({1'b0, aw_idx_q} < N_REGS_IDX) ? OKAY : SLVERR;
        regs_d  = regs_q;
        pulse_d = '0;
        if (wr_state_q == W_CAPT) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                if (aw_idx_q == IDX_W'(i)) begin
                    if (PULSE_MASK[i]) begin
                        pulse_d[i] = wdata_q & wmask;
                    end else if (!RO_MASK[i]) begin
                        regs_d[i] = (regs_q[i] & ~wmask) | (wdata_q & wmask);
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live_q    <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
            regs_q    <= '0;
            pulse_q   <= '0;
        end else begin
            live_q <= 1'b1;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= S_AXI_AWADDR[ADDR_W-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= S_AXI_WDATA;
                wstrb_q  <= S_AXI_WSTRB;
            end
            if (wr_state_q == W_CAPT) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bresp_q   <= bresp_d;
            end
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_q <= R_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = (rd_state_q == R_IDLE) && live_q;
        S_AXI_RVALID  = (rd_state_q == R_DATA);
    end

    // Sampled from regs_q, so a write landing on the same edge is not yet visible.
    always_comb begin
        rdata_d = '0;
        rresp_d = SLVERR;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rresp_d = OKAY;
                if (RO_MASK[i]) begin
                    rdata_d = status_i[i*DATA_W +: DATA_W];
                end else if (!PULSE_MASK[i]) begin
                    rdata_d = regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (ar_hs) begin
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

endmodule
